// File: rtl/db_to_ram_writeback.sv
// Copies database words back out to RAM, optionally unpacking 9 elements per word.
// `packed` is a SystemVerilog keyword, so the packed-mode input is named packed_i.
module db_to_ram_writeback #(
  parameter int SIZE_1           = 11,
  parameter int SIZE_address_pix = 13,
  parameter int SIZE_9           = 9 * SIZE_1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        packed_i,
  input  logic [12:0]                 base_addr,
  input  logic [SIZE_address_pix-1:0] count,
  output logic                        re_db,
  output logic [SIZE_address_pix-1:0] addr_db,
  input  logic [SIZE_9-1:0]           q_db,
  output logic                        we_RAM,
  output logic [12:0]                 address,
  output logic signed [SIZE_1-1:0]    data_out,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic                        packed_q, packed_d;
  logic [12:0]                 base_q, base_d;
  logic [SIZE_address_pix-1:0] count_q, count_d;
  logic [SIZE_address_pix-1:0] widx_q, widx_d;
  logic [3:0]                  eidx_q, eidx_d;
  logic [12:0]                 ridx_q, ridx_d;
  logic [SIZE_9-1:0]           word_q, word_d;
  logic                        re_db_q, re_db_d;
  logic [SIZE_address_pix-1:0] addr_db_q, addr_db_d;
  logic                        we_q, we_d;
  logic [12:0]                 address_q, address_d;
  logic [SIZE_1-1:0]           data_q, data_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  // Element 0 is the top slice; element 8 is the bottom slice (also the unpacked element).
  logic [SIZE_1-1:0] q_elem    [9];
  logic [SIZE_1-1:0] word_elem [9];

  for (genvar gi = 0; gi < 9; gi++) begin : g_slice
    assign q_elem[gi]    = q_db[SIZE_9-1-gi*SIZE_1 -: SIZE_1];
    assign word_elem[gi] = word_q[SIZE_9-1-gi*SIZE_1 -: SIZE_1];
  end

  logic [3:0] eidx_inc;
  logic       last_elem;
  assign eidx_inc  = eidx_q + 4'd1;
  assign last_elem = packed_q ? (eidx_q == 4'd8) : 1'b1;

  // Output registers are loaded with the values for the state being entered,
  // so every output lines up with its state without a combinational path.
  always_comb begin
    state_d   = state_q;
    packed_d  = packed_q;
    base_d    = base_q;
    count_d   = count_q;
    widx_d    = widx_q;
    eidx_d    = eidx_q;
    ridx_d    = ridx_q;
    word_d    = word_q;
    re_db_d   = 1'b0;
    addr_db_d = addr_db_q;
    we_d      = 1'b0;
    address_d = address_q;
    data_d    = data_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          packed_d = packed_i;
          base_d   = base_addr;
          count_d  = count;
          widx_d   = '0;
          eidx_d   = '0;
          ridx_d   = '0;
          if (count == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            re_db_d   = 1'b1;
            addr_db_d = '0;
            busy_d    = 1'b1;
          end
        end
      end
      S_RD: begin
        state_d = S_CAP;
        busy_d  = 1'b1;
      end
      S_CAP: begin
        // The first element comes straight from q_db since word_q loads on this same edge.
        word_d    = q_db;
        eidx_d    = '0;
        state_d   = S_WR;
        busy_d    = 1'b1;
        we_d      = 1'b1;
        address_d = base_q + ridx_q;
        data_d    = packed_q ? q_elem[0] : q_elem[8];
      end
      S_WR: begin
        ridx_d = ridx_q + 13'd1;
        if (!last_elem) begin
          eidx_d    = eidx_inc;
          busy_d    = 1'b1;
          we_d      = 1'b1;
          address_d = base_q + ridx_q + 13'd1;
          data_d    = word_elem[eidx_inc];
        end else if (widx_q == count_q - 1'b1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          widx_d    = widx_q + 1'b1;
          state_d   = S_RD;
          re_db_d   = 1'b1;
          addr_db_d = widx_q + 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      packed_q  <= 1'b0;
      base_q    <= '0;
      count_q   <= '0;
      widx_q    <= '0;
      eidx_q    <= '0;
      ridx_q    <= '0;
      word_q    <= '0;
      re_db_q   <= 1'b0;
      addr_db_q <= '0;
      we_q      <= 1'b0;
      address_q <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      packed_q  <= packed_d;
      base_q    <= base_d;
      count_q   <= count_d;
      widx_q    <= widx_d;
      eidx_q    <= eidx_d;
      ridx_q    <= ridx_d;
      word_q    <= word_d;
      re_db_q   <= re_db_d;
      addr_db_q <= addr_db_d;
      we_q      <= we_d;
      address_q <= address_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign re_db    = re_db_q;
  assign addr_db  = addr_db_q;
  assign we_RAM   = we_q;
  assign address  = address_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_db_to_ram_writeback.sv
// Bench for db_to_ram_writeback: table of transfers, scoreboard of expected RAM writes,
// plus hand-written reset and abort/restart sequences.
module tb_db_to_ram_writeback;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              pk_in;
  logic [12:0]       base_addr;
  logic [12:0]       count;
  logic              re_db;
  logic [12:0]       addr_db;
  logic [98:0]       q_db = '0;
  logic              we_RAM;
  logic [12:0]       address;
  logic signed [10:0] data_out;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  db_to_ram_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .packed_i(pk_in),
    .base_addr(base_addr), .count(count), .re_db(re_db), .addr_db(addr_db),
    .q_db(q_db), .we_RAM(we_RAM), .address(address), .data_out(data_out),
    .busy(busy), .done(done)
  );

  function automatic logic [98:0] rnd99();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[98:0];
  endfunction

  // Database model: data valid exactly one cycle after re_db, garbage otherwise.
  logic [98:0] db_mem [0:15];
  always @(posedge clk) begin
    if (re_db) q_db <= db_mem[addr_db[3:0]];
    else       q_db <= rnd99();
  end

  typedef struct {
    logic [12:0]        addr;
    logic signed [10:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    bit          pk;
    logic [12:0] base;
    logic [12:0] cnt;
    int          kind;     // 0 random data, 1 unpacked fixed data, 2 packed fixed data
    int          exp_w;
    int          exp_r;
    int          exp_last;
    int          exp_done;
    bit          jam;      // hold start high and scramble inputs while busy
  } vec_t;
  vec_t vecs[7];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [12:0] a, input logic signed [10:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic prepare(input vec_t v);
    logic [98:0]        w;
    logic signed [10:0] d;
    logic signed [10:0] fixed_u [4];
    logic [12:0]        a;
    fixed_u[0] = 11'sd5;
    fixed_u[1] = -11'sd3;
    fixed_u[2] = 11'sd1023;
    fixed_u[3] = -11'sd1024;
    a = v.base;
    for (int wi = 0; wi < int'(v.cnt); wi++) begin
      w = rnd99();
      if (v.kind == 1) w[10:0] = fixed_u[wi];
      if (v.kind == 2) begin
        for (int e = 0; e < 9; e++) begin
          d = (wi == 0) ? 11'(e + 1) : 11'(-(e + 1));
          w[98-11*e -: 11] = d;
        end
      end
      db_mem[wi] = w;
      if (v.pk) begin
        for (int e = 0; e < 9; e++) begin
          if (v.kind == 2) d = (wi == 0) ? 11'(e + 1) : 11'(-(e + 1));
          else             d = w[98-11*e -: 11];
          push(a, d);
          a = a + 13'd1;
        end
      end else begin
        push(a, (v.kind == 1) ? fixed_u[wi] : w[10:0]);
        a = a + 13'd1;
      end
    end
  endtask

  task automatic pop_check();
    wr_t e;
    if (exp_q.size() == 0) begin
      chk("wr_unexpected", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("wr_addr", address, e.addr);
      chk("wr_data", data_out, e.data);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int wr = 0, rd = 0, bz = 0, dn = 0, inv = 0;
    int first = -1, last = 0, drel = -1;
    bit fin = 0;
    prepare(v);
    @(negedge clk);
    pk_in = v.pk; base_addr = v.base; count = v.cnt; start = 1'b1;
    @(posedge clk);
    #1;
    if (!v.jam) start = 1'b0;
    pk_in = ~v.pk; base_addr = 13'($urandom); count = 13'($urandom);
    for (int rel = 1; rel <= 400 && !fin; rel++) begin
      @(negedge clk);
      if (we_RAM) begin
        wr++;
        if (first < 0) first = rel;
        last = rel;
        pop_check();
      end
      if (re_db) rd++;
      if (busy) bz++;
      if ((re_db && we_RAM) || (done && busy)) inv++;
      if (done) begin dn++; drel = rel; end
      if (dn > 0 && rel == drel + 1) start = 1'b0;
      if (dn > 0 && rel >= drel + 4) fin = 1;
    end
    start = 1'b0;
    if (!fin) chk("xfer_timeout", 0, 1);
    chk("n_writes", wr, v.exp_w);
    chk("n_reads", rd, v.exp_r);
    chk("n_done", dn, 1);
    chk("done_cycle", drel, v.exp_done);
    chk("busy_cycles", bz, v.exp_last);
    chk("invariants", inv, 0);
    chk("sb_left", exp_q.size(), 0);
    if (v.exp_w > 0) begin
      chk("first_we_cycle", first, 3);
      chk("last_we_cycle", last, v.exp_last);
    end
    $display("xfer pk=%0d base=%0d cnt=%0d: writes=%0d reads=%0d done@%0d errors=%0d",
             v.pk, v.base, v.cnt, wr, rd, drel, errors);
  endtask

  initial begin
    int wr, rd, dn;
    bit hit;
    vecs[0] = '{0, 13'd100,  13'd4, 1, 4,  4, 12, 13, 0};
    vecs[1] = '{1, 13'd0,    13'd2, 2, 18, 2, 22, 23, 0};
    vecs[2] = '{0, 13'd8191, 13'd3, 0, 3,  3, 9,  10, 1};
    vecs[3] = '{0, 13'd55,   13'd0, 0, 0,  0, 0,  1,  0};
    vecs[4] = '{1, 13'd8185, 13'd1, 0, 9,  1, 11, 12, 1};
    vecs[5] = '{0, 13'd2000, 13'd5, 0, 5,  5, 15, 16, 0};
    vecs[6] = '{1, 13'd0,    13'd0, 0, 0,  0, 0,  1,  1};

    rst_n = 1'b0; start = 1'b0; pk_in = 1'b0; base_addr = '0; count = '0;
    repeat (3) @(negedge clk);
    chk("rst_re_db", re_db, 0);
    chk("rst_addr_db", addr_db, 0);
    chk("rst_we_RAM", we_RAM, 0);
    chk("rst_address", address, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    rd = 0; wr = 0;
    repeat (10) begin
      @(negedge clk);
      if (re_db) rd++;
      if (we_RAM) wr++;
    end
    chk("idle_reads", rd, 0);
    chk("idle_writes", wr, 0);
    $display("reset: outputs checked, idle reads=%0d writes=%0d", rd, wr);

    for (int i = 0; i < 7; i++) run_xfer(vecs[i]);

    // Abort: reset during the third write of a packed transfer.
    for (int wi = 0; wi < 2; wi++) db_mem[wi] = rnd99();
    for (int e = 0; e < 3; e++) push(13'(300 + e), db_mem[0][98-11*e -: 11]);
    @(negedge clk);
    pk_in = 1'b1; base_addr = 13'd300; count = 13'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr = 0; hit = 0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (we_RAM) begin
        wr++;
        pop_check();
        if (wr == 3) hit = 1;
      end
    end
    chk("abort_reached_3rd", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_RAM", we_RAM, 0);
    chk("abort_busy", busy, 0);
    chk("abort_re_db", re_db, 0);
    chk("abort_address", address, 0);
    chk("abort_data_out", data_out, 0);
    wr = 0; dn = 0; rd = 0;
    repeat (3) begin
      @(negedge clk);
      if (we_RAM) wr++;
      if (done) dn++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (we_RAM) wr++;
      if (done) dn++;
      if (re_db) rd++;
    end
    chk("abort_no_writes", wr, 0);
    chk("abort_no_done", dn, 0);
    chk("abort_no_reads", rd, 0);
    chk("abort_sb_left", exp_q.size(), 0);
    $display("abort: writes=%0d done=%0d reads=%0d after reset", wr, dn, rd);

    run_xfer('{0, 13'd42, 13'd1, 0, 1, 1, 3, 4, 0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/db_to_ram_writeback.md
Name: db_to_ram_writeback

Overview:
- Return path of the neuroset memory interface: the layer loader moves RAM contents into the pixel/weight database; this block moves database contents back out to RAM.
- On `start` it reads `count` words from a database port, one at a time, and writes them to RAM beginning at `base_addr`.
- In packed mode each database word holds 9 kernel elements. Element 0 is the top slice [SIZE_9-1:SIZE_8]; element 8 is the bottom slice [SIZE_1-1:0]. The block unpacks each word into 9 consecutive RAM writes, top slice first.
- Used to dump layer results or weight banks to RAM for host readback and checking.

Parameters:
- SIZE_1, 11, width of one element; also the RAM data width.
- SIZE_address_pix, 13, database address width.
- SIZE_9, 9*SIZE_1, width of a packed database word (the element slices are multiples of SIZE_1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a transfer; sampled only in IDLE.
- packed  input  1  1 = 9 elements per word, 0 = one element per word in [SIZE_1-1:0]; sampled at start.
- base_addr  input  13  first RAM address; sampled at start.
- count  input  SIZE_address_pix  number of database words to read; sampled at start.
- re_db  output  1  database read enable.
- addr_db  output  SIZE_address_pix  database read address.
- q_db  input  SIZE_9  database read data, valid exactly 1 cycle after re_db.
- we_RAM  output  1  RAM write enable, 1-cycle pulse per element.
- address  output  13  RAM write address.
- data_out  output  signed SIZE_1  RAM write data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  1-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0, takes effect immediately, asynchronously): all outputs 0, FSM to IDLE, word and element counters 0, buffer 0.
- Reset mid-transfer aborts the transfer: no further we_RAM pulses, and no done pulse.
- Latched at start acceptance: base_addr, count and packed go into internal registers. Internal counters are widx (database word index), eidx (element index within a word) and ridx (RAM offset from base).
- FSM states:
  - IDLE: busy=0. On start=1: latch inputs, clear widx/eidx/ridx. Go to DONE if count==0, otherwise to RD.
  - RD (1 cycle): re_db=1, addr_db=widx. Next state CAP.
  - CAP (1 cycle): re_db=0; capture q_db into buf. Next state WR, eidx=0.
  - WR (1 cycle per element): we_RAM=1, address=base+ridx (13-bit, wraps modulo 8192), data_out=slice eidx of buf; then ridx++.
    - Last element is eidx==8 when packed, eidx==0 when unpacked.
    - If not the last element: eidx++ and stay in WR.
    - If last element and widx==count-1: go to DONE.
    - If last element otherwise: widx++ and go to RD.
  - DONE (1 cycle): done=1, busy=0, we_RAM=0. Next state IDLE.
- Throughput:
  - Unpacked: 3 cycles per word.
  - Packed: 11 cycles per word.
  - Total writes = count (unpacked) or 9*count (packed).
- First we_RAM appears 3 cycles after the start-accept edge.
- start while busy is ignored, and input changes while busy have no effect.
- start asserted in the DONE cycle is ignored; a new start is accepted in IDLE on the following cycle.
- Data is passed through unchanged: the signed slice is copied bit-exact, with no sign extension or rounding.
- we_RAM is never asserted outside WR. re_db is never asserted outside RD.

Test Plan:
- Reset check: hold rst_n=0 → all outputs 0. Release, wait 10 cycles with no start → no re_db, no we_RAM.
- Unpacked transfer: count=4, base=100, database words 0..3 hold 5, -3, 1023, -1024 → writes to addresses 100..103 with those values in order; done 1 cycle after the 4th write; 12 cycles from start to the last write inclusive.
- Packed transfer: count=2, base=0; word0 slices = 1..9 (top slice first), word1 slices = -1..-9 → 18 writes to addresses 0..17 with values 1..9 then -1..-9; re_db asserted exactly twice.
- Address wrap: unpacked, count=3, base=8191 → writes to addresses 8191, 0, 1.
- count=0 with start → no re_db, no we_RAM; done pulses 1 cycle after start; busy never high.
- Abort and restart: pull rst_n low during the 3rd write of a packed transfer → we_RAM drops immediately and no done pulse. After release, start with count=1 unpacked → exactly one correct write followed by done.
